gbf_pingpong_ctrl: RTL and testbench
====================================

// Module: gbf_pingpong_ctrl
// PURPOSE
//  Ping-pong scheduler for a pair of simple_dp_ram global-buffer banks (e.g. gbf_actv_buf1/2).
//  Producer side (DRAM loader) fills one bank while consumer side (PE-array feeder) drains the other.
//  Consumer may re-read a tile several times (reuse). Controller owns all RAM enables and addresses.
// PARAMETERS
//  DATA_BITWIDTH  256  word width of both banks
//  ADDR_BITWIDTH  5    bank address width
//  DEPTH          32   words per bank
//  TILE_BITWIDTH  8    width of tile counter
// PORTS
//  clk          in   1               clock; all logic on posedge (RAMs use negedge internally)
//  rst_n        in   1               synchronous active-low reset
//  start        in   1               1-cycle pulse, latches cfg_* when busy=0
//  cfg_wr_len   in   ADDR_BITWIDTH+1 words written per tile, 1..DEPTH
//  cfg_rd_len   in   ADDR_BITWIDTH+1 words read per pass, 1..cfg_wr_len
//  cfg_rd_rep   in   4               passes per tile, 1..15
//  cfg_tiles    in   TILE_BITWIDTH   tiles per run, >=1
//  busy / done / cfg_err  out 1      run active / 1-cycle end pulse / 1-cycle bad-config pulse
//  wr_valid, wr_ready  in/out 1      producer handshake; transfer when both high
//  wr_data      in   DATA_BITWIDTH   producer word
//  rd_req, rd_ready    in/out 1      consumer handshake; accept when both high
//  rd_valid     out  1               rd_data valid
//  rd_data      out  DATA_BITWIDTH   registered read word
//  ram_ena, ram_wea    out 2         per-bank port-A enable/write (bit i = bank i)
//  ram_addra, ram_addrb out ADDR_BITWIDTH  shared addresses; ram_dia out DATA_BITWIDTH
//  ram_enb      out  2               per-bank port-B read enable
//  ram_dob0, ram_dob1  in DATA_BITWIDTH  bank read data
// BEHAVIOUR
//  Reset: all outputs 0; both banks EMPTY; wsel=rsel=0; counters 0.
//  Per-bank state: EMPTY -> FILLING (first write) -> FULL (cfg_wr_len-th write)
//   -> DRAINING (first read) -> EMPTY (last word of last pass).
//  start with busy=0: cfg_wr_len==0, cfg_rd_len==0, cfg_rd_len>cfg_wr_len, cfg_rd_rep==0 or
//   cfg_tiles==0 -> cfg_err=1 one cycle, busy stays 0. Else latch cfg, busy=1 next cycle.
//  start while busy=1 ignored. cfg_* only sampled on accepted start.
//  wr_ready = busy & bank[wsel] in {EMPTY,FILLING} & tiles_filled<cfg_tiles (combinational).
//  Write xfer: ram_ena[wsel]=ram_wea[wsel]=1, ram_addra=wr_ptr, ram_dia=wr_data same cycle;
//   wr_ptr++; on cfg_wr_len-th word: wr_ptr=0, bank FULL, wsel toggles, tiles_filled++.
//  rd_ready = busy & bank[rsel] in {FULL,DRAINING}.
//  Read accept: ram_enb[rsel]=1, ram_addrb=rd_ptr; next cycle rd_valid=1,
//   rd_data=dob of that bank (latency 1). rd_ptr wraps to 0 after cfg_rd_len-1, rep++;
//   after last pass: bank EMPTY, rsel toggles, rep=0, tiles_drained++.
//  Banks never written and read in same cycle: write bank must be EMPTY/FILLING, read bank
//   FULL/DRAINING, so simultaneous wr/rd always target different banks; both allowed per cycle.
//  Words cfg_rd_len..cfg_wr_len-1 of a tile are written but never read (legal).
//  Both banks FULL/DRAINING: wr_ready=0 (backpressure). Both EMPTY/FILLING: rd_ready=0.
//  Run end: when tiles_drained==cfg_tiles after a bank release -> done=1 one cycle, busy=0.
//  Inactive ram_* enables are 0; addresses/dia hold last value. rst_n low mid-run aborts
//   immediately to reset state; bank contents are not cleared.
// CONFIGURATION
//  GBF_PERF_CNT_EN defined: adds outputs perf_wr_stall[31:0] (cycles wr_valid & !wr_ready & busy)
//   and perf_rd_stall[31:0] (cycles rd_req & !rd_ready & busy); cleared on accepted start and
//   reset, saturate at all-ones. Not defined: ports and counters absent, no other change.
// TESTING
//  1 tile, wr_len=4, rd_len=4, rep=1: write 4 words A0..A3 -> reads return A0..A3, rd_valid 1 cycle
//   after each accept, done pulses once, busy falls same cycle.
//  tiles=3, wr_len=8, rd_len=8, rep=2, continuous wr_valid/rd_req -> tile1 filled into bank1 while
//   bank0 drains; read sequence T0x2, T1x2, T2x2; ram_ena/ram_enb never high on same bank.
//  Consumer idle, tiles=4: after 16 writes (wr_len=8) wr_ready=0; one full drain re-opens bank0.
//  rd_req before any write -> rd_ready=0, no ram_enb; with PERF_CNT_EN perf_rd_stall counts cycles.
//  start with cfg_rd_len=9, cfg_wr_len=8 -> cfg_err=1 one cycle, busy=0; start while busy ignored.
//  rst_n=0 mid-tile-2 -> next cycle all outputs 0, banks EMPTY; fresh start runs correctly.

Source files
------------

// File: rtl/gbf_pingpong_ctrl.sv
// Ping-pong scheduler for two global-buffer banks: producer fills one bank while consumer drains the other.
// Optional stall counters are compiled in with `define GBF_PERF_CNT_EN.
module gbf_pingpong_ctrl #(
    parameter int DATA_BITWIDTH = 256,
    parameter int ADDR_BITWIDTH = 5,
    parameter int DEPTH         = 32,
    parameter int TILE_BITWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_BITWIDTH:0]   cfg_wr_len,
    input  logic [ADDR_BITWIDTH:0]   cfg_rd_len,
    input  logic [3:0]               cfg_rd_rep,
    input  logic [TILE_BITWIDTH-1:0] cfg_tiles,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [DATA_BITWIDTH-1:0] wr_data,
    input  logic                     rd_req,
    output logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DATA_BITWIDTH-1:0] rd_data,
    output logic [1:0]               ram_ena,
    output logic [1:0]               ram_wea,
    output logic [ADDR_BITWIDTH-1:0] ram_addra,
    output logic [ADDR_BITWIDTH-1:0] ram_addrb,
    output logic [DATA_BITWIDTH-1:0] ram_dia,
    output logic [1:0]               ram_enb,
    input  logic [DATA_BITWIDTH-1:0] ram_dob0,
    input  logic [DATA_BITWIDTH-1:0] ram_dob1
`ifdef GBF_PERF_CNT_EN
    ,
    output logic [31:0]              perf_wr_stall,
    output logic [31:0]              perf_rd_stall
`endif
);

    localparam int CW = ADDR_BITWIDTH + 1;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_e;

    typedef enum logic {
        RUN_IDLE,
        RUN_ACTIVE
    } run_state_e;

    run_state_e               run_q, run_d;
    bank_state_e              bank_q [2];
    bank_state_e              bank_d [2];
    logic                     wsel_q, wsel_d, rsel_q, rsel_d;
    logic [ADDR_BITWIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]               rep_q, rep_d;
    logic [TILE_BITWIDTH-1:0] tiles_filled_q, tiles_filled_d;
    logic [TILE_BITWIDTH-1:0] tiles_drained_q, tiles_drained_d;
    logic [CW-1:0]            cfg_wr_len_q, cfg_wr_len_d, cfg_rd_len_q, cfg_rd_len_d;
    logic [3:0]               cfg_rd_rep_q, cfg_rd_rep_d;
    logic [TILE_BITWIDTH-1:0] cfg_tiles_q, cfg_tiles_d;
    logic                     done_q, done_d, cfg_err_q, cfg_err_d;
    logic                     rd_valid_q, rd_valid_d;
    logic [DATA_BITWIDTH-1:0] rd_data_q, rd_data_d;
    logic [ADDR_BITWIDTH-1:0] addra_q, addra_d, addrb_q, addrb_d;
    logic [DATA_BITWIDTH-1:0] dia_q, dia_d;

    logic cfg_bad, start_ok, wr_xfer, rd_xfer;
    logic wr_last, rd_last_word, rd_last_pass;

    // Lengths above DEPTH would wrap the bank address, so they are rejected with the other bad configs.
    assign cfg_bad = (cfg_wr_len == '0) || (cfg_wr_len > CW'(DEPTH)) || (cfg_rd_len == '0) ||
                     (cfg_rd_len > cfg_wr_len) || (cfg_rd_rep == '0) || (cfg_tiles == '0);
    assign start_ok = start && (run_q == RUN_IDLE) && !cfg_bad;

    assign busy     = (run_q == RUN_ACTIVE);
    assign wr_ready = busy && (bank_q[wsel_q] == BANK_EMPTY || bank_q[wsel_q] == BANK_FILLING) &&
                      (tiles_filled_q < cfg_tiles_q);
    assign rd_ready = busy && (bank_q[rsel_q] == BANK_FULL || bank_q[rsel_q] == BANK_DRAINING);
    assign wr_xfer  = wr_valid && wr_ready;
    assign rd_xfer  = rd_req && rd_ready;

    assign wr_last      = ({1'b0, wr_ptr_q} == cfg_wr_len_q - CW'(1));
    assign rd_last_word = ({1'b0, rd_ptr_q} == cfg_rd_len_q - CW'(1));
    assign rd_last_pass = (rep_q == cfg_rd_rep_q - 4'd1);

    // Write and read banks are always distinct, so these enables never collide on one bank.
    assign ram_ena   = {wr_xfer && wsel_q, wr_xfer && !wsel_q};
    assign ram_wea   = ram_ena;
    assign ram_enb   = {rd_xfer && rsel_q, rd_xfer && !rsel_q};
    assign ram_addra = wr_xfer ? wr_ptr_q : addra_q;
    assign ram_addrb = rd_xfer ? rd_ptr_q : addrb_q;
    assign ram_dia   = wr_xfer ? wr_data : dia_q;

    assign done     = done_q;
    assign cfg_err  = cfg_err_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

    // NOTE: combinational next-state logic uses blocking '=' with every target defaulted first,
    // so no latches are inferred; the registers below use non-blocking '<=' only.
    always_comb begin
        run_d           = run_q;
        bank_d          = bank_q;
        wsel_d          = wsel_q;
        rsel_d          = rsel_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        rep_d           = rep_q;
        tiles_filled_d  = tiles_filled_q;
        tiles_drained_d = tiles_drained_q;
        cfg_wr_len_d    = cfg_wr_len_q;
        cfg_rd_len_d    = cfg_rd_len_q;
        cfg_rd_rep_d    = cfg_rd_rep_q;
        cfg_tiles_d     = cfg_tiles_q;
        done_d          = 1'b0;
        cfg_err_d       = 1'b0;
        rd_valid_d      = rd_xfer;
        rd_data_d       = rd_data_q;
        addra_d         = addra_q;
        addrb_d         = addrb_q;
        dia_d           = dia_q;

        if (run_q == RUN_IDLE) begin
            if (start && cfg_bad) begin
                cfg_err_d = 1'b1;
            end else if (start_ok) begin
                run_d           = RUN_ACTIVE;
                cfg_wr_len_d    = cfg_wr_len;
                cfg_rd_len_d    = cfg_rd_len;
                cfg_rd_rep_d    = cfg_rd_rep;
                cfg_tiles_d     = cfg_tiles;
                wsel_d          = 1'b0;
                rsel_d          = 1'b0;
                wr_ptr_d        = '0;
                rd_ptr_d        = '0;
                rep_d           = '0;
                tiles_filled_d  = '0;
                tiles_drained_d = '0;
            end
        end else begin
            if (wr_xfer) begin
                addra_d = wr_ptr_q;
                dia_d   = wr_data;
                if (wr_last) begin
                    wr_ptr_d         = '0;
                    bank_d[wsel_q]   = BANK_FULL;
                    wsel_d           = !wsel_q;
                    tiles_filled_d   = tiles_filled_q + TILE_BITWIDTH'(1);
                end else begin
                    wr_ptr_d         = wr_ptr_q + ADDR_BITWIDTH'(1);
                    bank_d[wsel_q]   = BANK_FILLING;
                end
            end
            if (rd_xfer) begin
                addrb_d   = rd_ptr_q;
                // Bank RAMs read on the falling edge, so dob already holds this word at the next rising edge.
                rd_data_d = rsel_q ? ram_dob1 : ram_dob0;
                if (rd_last_word && rd_last_pass) begin
                    rd_ptr_d        = '0;
                    rep_d           = '0;
                    bank_d[rsel_q]  = BANK_EMPTY;
                    rsel_d          = !rsel_q;
                    tiles_drained_d = tiles_drained_q + TILE_BITWIDTH'(1);
                    if (tiles_drained_q + TILE_BITWIDTH'(1) == cfg_tiles_q) begin
                        done_d = 1'b1;
                        run_d  = RUN_IDLE;
                    end
                end else if (rd_last_word) begin
                    rd_ptr_d       = '0;
                    rep_d          = rep_q + 4'd1;
                    bank_d[rsel_q] = BANK_DRAINING;
                end else begin
                    rd_ptr_d       = rd_ptr_q + ADDR_BITWIDTH'(1);
                    bank_d[rsel_q] = BANK_DRAINING;
                end
            end
        end
    end

    // NOTE: reset only clears control state; the bank RAM contents live outside and are left untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q           <= RUN_IDLE;
            bank_q[0]       <= BANK_EMPTY;
            bank_q[1]       <= BANK_EMPTY;
            wsel_q          <= 1'b0;
            rsel_q          <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            rep_q           <= '0;
            tiles_filled_q  <= '0;
            tiles_drained_q <= '0;
            cfg_wr_len_q    <= '0;
            cfg_rd_len_q    <= '0;
            cfg_rd_rep_q    <= '0;
            cfg_tiles_q     <= '0;
            done_q          <= 1'b0;
            cfg_err_q       <= 1'b0;
            rd_valid_q      <= 1'b0;
            rd_data_q       <= '0;
            addra_q         <= '0;
            addrb_q         <= '0;
            dia_q           <= '0;
        end else begin
            run_q           <= run_d;
            bank_q          <= bank_d;
            wsel_q          <= wsel_d;
            rsel_q          <= rsel_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            rep_q           <= rep_d;
            tiles_filled_q  <= tiles_filled_d;
            tiles_drained_q <= tiles_drained_d;
            cfg_wr_len_q    <= cfg_wr_len_d;
            cfg_rd_len_q    <= cfg_rd_len_d;
            cfg_rd_rep_q    <= cfg_rd_rep_d;
            cfg_tiles_q     <= cfg_tiles_d;
            done_q          <= done_d;
            cfg_err_q       <= cfg_err_d;
            rd_valid_q      <= rd_valid_d;
            rd_data_q       <= rd_data_d;
            addra_q         <= addra_d;
            addrb_q         <= addrb_d;
            dia_q           <= dia_d;
        end
    end

`ifdef GBF_PERF_CNT_EN
    logic [31:0] perf_wr_stall_q, perf_wr_stall_d, perf_rd_stall_q, perf_rd_stall_d;

    always_comb begin
        perf_wr_stall_d = perf_wr_stall_q;
        perf_rd_stall_d = perf_rd_stall_q;
        if (start_ok) begin
            perf_wr_stall_d = '0;
            perf_rd_stall_d = '0;
        end else begin
            if (busy && wr_valid && !wr_ready && !(&perf_wr_stall_q))
                perf_wr_stall_d = perf_wr_stall_q + 32'd1;
            if (busy && rd_req && !rd_ready && !(&perf_rd_stall_q))
                perf_rd_stall_d = perf_rd_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_wr_stall_q <= '0;
            perf_rd_stall_q <= '0;
        end else begin
            perf_wr_stall_q <= perf_wr_stall_d;
            perf_rd_stall_q <= perf_rd_stall_d;
        end
    end

    assign perf_wr_stall = perf_wr_stall_q;
    assign perf_rd_stall = perf_rd_stall_q;
`endif

endmodule

// File: tb/tb_gbf_pingpong_ctrl.sv
// Directed bench for gbf_pingpong_ctrl with two negedge-clocked bank RAM models.
// Config rejection is table-driven; multi-cycle runs use a producer/consumer cycle task and a read scoreboard.
module tb_gbf_pingpong_ctrl;

    localparam int DW = 256;
    localparam int AW = 5;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW:0]   cfg_wr_len, cfg_rd_len;
    logic [3:0]    cfg_rd_rep;
    logic [TW-1:0] cfg_tiles;
    logic          busy, done, cfg_err;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_req, rd_ready, rd_valid;
    logic [DW-1:0] rd_data;
    logic [1:0]    ram_ena, ram_wea, ram_enb;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic [DW-1:0] ram_dia;
    logic [DW-1:0] ram_dob0 = '0, ram_dob1 = '0;
`ifdef GBF_PERF_CNT_EN
    logic [31:0]   perf_wr_stall, perf_rd_stall;
`endif

    gbf_pingpong_ctrl #(
        .DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .DEPTH(32), .TILE_BITWIDTH(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_wr_len(cfg_wr_len), .cfg_rd_len(cfg_rd_len), .cfg_rd_rep(cfg_rd_rep), .cfg_tiles(cfg_tiles),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_req(rd_req), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_addrb(ram_addrb),
        .ram_dia(ram_dia), .ram_enb(ram_enb), .ram_dob0(ram_dob0), .ram_dob1(ram_dob1)
`ifdef GBF_PERF_CNT_EN
        , .perf_wr_stall(perf_wr_stall), .perf_rd_stall(perf_rd_stall)
`endif
    );

    always #5 clk = ~clk;

    // Bank models: write and read on the falling edge, like simple_dp_ram.
    logic [DW-1:0] mem0 [32];
    logic [DW-1:0] mem1 [32];
    int collisions = 0;
    bit overlap_seen = 1'b0;

    always @(negedge clk) begin
        if (ram_ena[0] && ram_wea[0]) mem0[ram_addra] <= ram_dia;
        if (ram_ena[1] && ram_wea[1]) mem1[ram_addra] <= ram_dia;
        if (ram_enb[0]) ram_dob0 <= mem0[ram_addrb];
        if (ram_enb[1]) ram_dob1 <= mem1[ram_addrb];
        if ((ram_ena & ram_enb) != 2'b00) collisions++;
        if (ram_ena == 2'b10 && ram_enb == 2'b01) overlap_seen = 1'b1;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard state shared by the run tasks (only the single initial process touches it).
    logic [DW-1:0] exp_q [$];
    int run_id = 0, tw, iw, cfg_t, cfg_wl;
    int wr_count, done_cnt = 0, lat_err = 0;
    bit rd_fire_prev;

    function automatic logic [DW-1:0] data_word(input int r, input int t, input int i);
        logic [31:0] w;
        w = 32'hA000_0000 + 32'(r) * 32'h1_0000 + 32'(t) * 32'h100 + 32'(i);
        return {8{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int wl, input int rl, input int rep, input int tiles);
        run_id++;
        exp_q.delete();
        for (int t = 0; t < tiles; t++)
            for (int p = 0; p < rep; p++)
                for (int i = 0; i < rl; i++)
                    exp_q.push_back(data_word(run_id, t, i));
        tw = 0; iw = 0; cfg_t = tiles; cfg_wl = wl; wr_count = 0; rd_fire_prev = 1'b0;
        cfg_wr_len = (AW+1)'(wl); cfg_rd_len = (AW+1)'(rl); cfg_rd_rep = 4'(rep); cfg_tiles = TW'(tiles);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_accepted_busy", busy, 1'b1);
    endtask

    // One clock of producer/consumer activity; entered and left at posedge+1.
    task automatic cycle(input bit wr_en, input bit rd_en);
        bit wr_fire, rd_fire;
        if (done) begin
            done_cnt++;
            check("busy_low_with_done", busy, 1'b0);
        end
        if (rd_valid !== rd_fire_prev) lat_err++;
        if (rd_valid) begin
            if (exp_q.size() == 0) check("rd_unexpected_word", 1'b1, 1'b0);
            else check("rd_data", rd_data, exp_q.pop_front());
        end
        wr_valid = wr_en && (tw < cfg_t);
        wr_data  = data_word(run_id, tw, iw);
        rd_req   = rd_en;
        #2;
        wr_fire = wr_valid && wr_ready;
        rd_fire = rd_req && rd_ready;
        tick();
        if (wr_fire) begin
            wr_count++;
            iw++;
            if (iw == cfg_wl) begin
                iw = 0;
                tw++;
            end
        end
        rd_fire_prev = rd_fire;
    endtask

    task automatic run_to_done(input int budget);
        int d0 = done_cnt;
        for (int n = 0; n < budget && done_cnt == d0; n++) cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b0);
        check("done_pulses_once", 32'(done_cnt - d0), 32'd1);
        check("busy_low_after_run", busy, 1'b0);
        check("all_reads_returned", 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        int wl, rl, rep, tiles;
        bit exp_err;
    } cfg_vec_t;

    cfg_vec_t vecs [8];

    initial begin
        vecs[0] = '{0, 1, 1, 1, 1'b1};
        vecs[1] = '{4, 0, 1, 1, 1'b1};
        vecs[2] = '{8, 9, 1, 1, 1'b1};
        vecs[3] = '{4, 4, 0, 1, 1'b1};
        vecs[4] = '{4, 4, 1, 0, 1'b1};
        vecs[5] = '{1, 1, 1, 1, 1'b0};
        vecs[6] = '{8, 8, 2, 3, 1'b0};
        vecs[7] = '{32, 1, 15, 255, 1'b0};

        rst_n = 1'b0; start = 1'b0; wr_valid = 1'b0; rd_req = 1'b0; wr_data = '0;
        cfg_wr_len = '0; cfg_rd_len = '0; cfg_rd_rep = '0; cfg_tiles = '0;
        repeat (3) tick();
        check("reset_ctrl_outputs", {busy, done, cfg_err, wr_ready, rd_ready, rd_valid}, '0);
        check("reset_ram_enables", {ram_ena, ram_wea, ram_enb}, '0);
        check("reset_rd_data", rd_data, '0);
        rst_n = 1'b1;
        tick();

        // Config acceptance / rejection table.
        for (int v = 0; v < 8; v++) begin
            cfg_wr_len = (AW+1)'(vecs[v].wl); cfg_rd_len = (AW+1)'(vecs[v].rl);
            cfg_rd_rep = 4'(vecs[v].rep);     cfg_tiles  = TW'(vecs[v].tiles);
            start = 1'b1;
            tick();
            start = 1'b0;
            check($sformatf("cfg_err_vec%0d", v), cfg_err, vecs[v].exp_err);
            check($sformatf("busy_vec%0d", v), busy, !vecs[v].exp_err);
            tick();
            check($sformatf("cfg_err_one_cycle_vec%0d", v), cfg_err, 1'b0);
            if (busy) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
        end

        // Single tile, 4 words, one pass; a bad start mid-run must be ignored.
        start_run(4, 4, 1, 1);
        cfg_wr_len = 7'd8; cfg_rd_len = 7'd9; cfg_rd_rep = 4'd1; cfg_tiles = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_while_busy_no_err", cfg_err, 1'b0);
        check("start_while_busy_stays_busy", busy, 1'b1);
        run_to_done(100);

        // Three tiles, two passes each, continuous traffic on both sides.
        start_run(8, 8, 2, 3);
        run_to_done(400);
        check("fill_overlaps_drain", overlap_seen, 1'b1);

        // Consumer idle: two banks fill, then backpressure until bank0 drains.
        start_run(8, 8, 1, 4);
        repeat (20) cycle(1'b1, 1'b0);
        check("writes_before_backpressure", 32'(wr_count), 32'd16);
        check("wr_ready_low_both_full", wr_ready, 1'b0);
        repeat (8) cycle(1'b0, 1'b1);
        check("wr_ready_after_drain", wr_ready, 1'b1);
        run_to_done(400);

        // Read request before any data has been written.
        start_run(4, 4, 1, 1);
        rd_req = 1'b1;
        wr_valid = 1'b0;
        for (int n = 0; n < 5; n++) begin
            #2;
            check("rd_ready_low_when_empty", rd_ready, 1'b0);
            check("no_enb_when_empty", ram_enb, 2'b00);
            @(posedge clk);
            #1;
        end
`ifdef GBF_PERF_CNT_EN
        check("perf_rd_stall_count", perf_rd_stall, 32'd5);
        check("perf_wr_stall_zero", perf_wr_stall, 32'd0);
`endif
        rd_req = 1'b0;
        run_to_done(100);

        // Reset in the middle of tile 2, then a fresh run.
        start_run(8, 8, 2, 3);
        for (int n = 0; n < 300 && !(tw == 2 && iw >= 3); n++) cycle(1'b1, 1'b1);
        check("reached_tile2", (tw == 2), 1'b1);
        rst_n = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;
        tick();
        check("midrun_reset_ctrl", {busy, done, cfg_err, wr_ready, rd_ready, rd_valid}, '0);
        check("midrun_reset_ram_ctl", {ram_ena, ram_wea, ram_enb, ram_addra, ram_addrb}, '0);
        check("midrun_reset_dia", ram_dia, '0);
        check("midrun_reset_rd_data", rd_data, '0);
        rst_n = 1'b1;
        tick();
        start_run(4, 4, 1, 1);
        run_to_done(100);

        check("rd_valid_latency_errors", 32'(lat_err), 32'd0);
        check("same_bank_wr_rd_collisions", 32'(collisions), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
